writeback_arbiter: RTL and testbench

- Sits between the execute/memory pipeline and the register file. Drives the register file write port: rd, wr_en, rd_value.
- Merges two result sources:
  - the in-order pipeline result, which may be an ALU result or raw load data;
  - the long-latency unit result (mul/div), buffered in a small FIFO.
- Aligns and sign-/zero-extends load data.
- Enforces x0 suppression.
- Prevents starvation of buffered long-latency results by stalling the pipeline.

---
 rtl/wb_pkg.sv | 59 +++++
 rtl/wb_result_fifo.sv | 70 +++++++
 rtl/writeback_arbiter.sv | 177 +++++++++++++++++
 tb/tb_writeback_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback arbiter:
//   - load funct3 encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
//   - wb_fifo_entry_t : buffered long-latency result {rd, data}
//   - wb_load_t       : result of load alignment {misalign, value}
//   - load_align()    : picks the byte/halfword/word at the byte offset and
//                       sign-/zero-extends it; flags illegal alignments
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_fifo_entry_t;

    typedef struct packed {
        logic        misalign;
        logic [31:0] value;
    } wb_load_t;

    // Unknown funct3 encodings fall into the default arm and behave as LW.
    function automatic wb_load_t load_align(input logic [31:0] word,
                                            input logic [2:0]  funct3,
                                            input logic [1:0]  off);
        wb_load_t    res;
        logic [31:0] shifted;
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        shifted  = word >> {off, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = off[1] ? word[31:16] : word[15:0];
        res      = '0;
        case (funct3)
            F3_LB:  res.value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: res.value = {24'h0, byte_sel};
            F3_LH: begin
                res.value    = {{16{half_sel[15]}}, half_sel};
                res.misalign = off[0];
            end
            F3_LHU: begin
                res.value    = {16'h0, half_sel};
                res.misalign = off[0];
            end
            default: begin
                res.value    = word;
                res.misalign = (off != 2'b00);
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// -----------------------------------------------------------------------------
// wb_result_fifo
// Synchronous FIFO buffering long-latency results until the register file
// write port is free. Show-ahead: dout always presents the head entry.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset (empties the FIFO)
//   push, din    write an entry (ignored when full)
//   pop          remove the head entry (ignored when empty)
//   dout         head entry
//   count        number of stored entries
//   full, empty  status flags derived from count
// Parameter FIFO_DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic                              pop,
    input  wb_fifo_entry_t                    din,
    output wb_fifo_entry_t                    dout,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              full,
    output logic                              empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    wb_fifo_entry_t r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign full      = (r_count == CW'(FIFO_DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // NOTE: the storage array has no reset; resetting the pointers and count
    // is enough to discard stale entries, since dout is only used when !empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    // NOTE: sequential state is always assigned with <= so that every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Drives the register file write port from two sources: the in-order pipeline
// result (ALU result or raw load word, aligned here) and buffered long-latency
// (mul/div) results. The FIFO head wins when the pipeline is idle or when the
// starve counter forces a one-cycle pipe_stall.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   wb_valid, wb_rd, wb_data         pipeline result
//   wb_is_load, wb_funct3, wb_addr_lo load alignment controls
//   wb_accept                        pipeline result consumed (combinational)
//   lu_valid, lu_rd, lu_data         long-latency result offer
//   lu_ready                         FIFO can accept (registered)
//   pipe_stall                       pipeline must hold (registered)
//   misalign                         one-cycle pulse on illegal load alignment
//   rd, wr_en, rd_value              register file write port (registered)
//   pending_mask                     only with WB_PENDING_MASK_EN: bit n set
//                                    while a buffered entry targets xn
// Optional feature macro: WB_PENDING_MASK_EN
// -----------------------------------------------------------------------------
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        wb_is_load,
    input  logic [2:0]  wb_funct3,
    input  logic [1:0]  wb_addr_lo,
    output logic        wb_accept,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        pipe_stall,
    output logic        misalign,
    output logic [4:0]  rd,
    output logic        wr_en,
    output logic [31:0] rd_value
`ifdef WB_PENDING_MASK_EN
    ,
    output logic [31:0] pending_mask
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic           r_lu_ready;
    logic           r_pipe_stall;
    logic           r_misalign;
    logic [4:0]     r_rd;
    logic           r_wr_en;
    logic [31:0]    r_rd_value;
    logic [SW-1:0]  r_starve;

    logic           w_push;
    logic           w_grant_lu;
    logic           w_grant_wb;
    logic           w_empty;
    logic           w_full;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_count_nxt;
    logic [SW-1:0]  w_starve_nxt;
    wb_fifo_entry_t w_din;
    wb_fifo_entry_t w_head;
    wb_load_t       w_load;

    // Entries for x0 are accepted (handshake completes) but never stored.
    assign w_push    = lu_valid & r_lu_ready & (lu_rd != 5'd0);
    assign w_din     = '{rd: lu_rd, data: lu_data};

    // Head wins on a forced stall or whenever the pipeline has nothing.
    assign w_grant_lu = ~w_empty & (r_pipe_stall | ~wb_valid);
    assign w_grant_wb = wb_valid & ~r_pipe_stall & ~w_grant_lu;
    assign wb_accept  = w_grant_wb;

    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_grant_lu);
    assign w_load      = load_align(wb_data, wb_funct3, wb_addr_lo);

    wb_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_grant_lu),
        .din   (w_din),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_starve_nxt = '0;
        if (!w_empty && !w_grant_lu && (r_starve != SW'(STARVE_LIMIT))) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lu_ready   <= 1'b1;
            r_pipe_stall <= 1'b0;
            r_misalign   <= 1'b0;
            r_rd         <= '0;
            r_wr_en      <= 1'b0;
            r_rd_value   <= '0;
            r_starve     <= '0;
        end else begin
            r_lu_ready   <= (w_count_nxt < CW'(FIFO_DEPTH));
            r_starve     <= w_starve_nxt;
            // Stall is raised in the same cycle the counter shows the limit,
            // which forces the head grant and clears the counter next edge.
            r_pipe_stall <= (w_starve_nxt == SW'(STARVE_LIMIT));
            r_misalign   <= w_grant_wb & wb_is_load & w_load.misalign;
            r_wr_en      <= 1'b0;
            if (w_grant_lu) begin
                r_wr_en    <= 1'b1;
                r_rd       <= w_head.rd;
                r_rd_value <= w_head.data;
            end else if (w_grant_wb && (wb_rd != 5'd0)
                         && !(wb_is_load && w_load.misalign)) begin
                r_wr_en    <= 1'b1;
                r_rd       <= wb_rd;
                r_rd_value <= wb_is_load ? w_load.value : wb_data;
            end
        end
    end

    assign lu_ready   = r_lu_ready;
    assign pipe_stall = r_pipe_stall;
    assign misalign   = r_misalign;
    assign rd         = r_rd;
    assign wr_en      = r_wr_en;
    assign rd_value   = r_rd_value;

`ifdef WB_PENDING_MASK_EN
    // Per-register occupancy counts; a bit is pending while its count is
    // nonzero. Counts track push/pop so the mask follows every enqueue and
    // dequeue without scanning the FIFO.
    logic [CW-1:0] r_pend_cnt [32];
    logic [CW-1:0] w_pend_nxt [32];
    logic [31:0]   r_pending_mask;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            w_pend_nxt[i] = r_pend_cnt[i]
                          + CW'(w_push && (lu_rd == 5'(i)))
                          - CW'(w_grant_lu && (w_head.rd == 5'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_pend_cnt[i] <= '0;
            r_pending_mask <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                r_pend_cnt[i]     <= w_pend_nxt[i];
                r_pending_mask[i] <= (i != 0) && (w_pend_nxt[i] != '0);
            end
        end
    end

    assign pending_mask = r_pending_mask;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
// Directed bench for writeback_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=8).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_is_load;
    logic [2:0]  wb_funct3;
    logic [1:0]  wb_addr_lo;
    logic        wb_accept;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        pipe_stall;
    logic        misalign;
    logic [4:0]  rd;
    logic        wr_en;
    logic [31:0] rd_value;
`ifdef WB_PENDING_MASK_EN
    logic [31:0] pending_mask;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    writeback_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_is_load (wb_is_load),
        .wb_funct3  (wb_funct3),
        .wb_addr_lo (wb_addr_lo),
        .wb_accept  (wb_accept),
        .lu_valid   (lu_valid),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .pipe_stall (pipe_stall),
        .misalign   (misalign),
        .rd         (rd),
        .wr_en      (wr_en),
        .rd_value   (rd_value)
`ifdef WB_PENDING_MASK_EN
        ,
        .pending_mask (pending_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] r, input logic [31:0] d,
                          input logic ld, input logic [2:0] f3, input logic [1:0] off);
        wb_valid   = v;
        wb_rd      = r;
        wb_data    = d;
        wb_is_load = ld;
        wb_funct3  = f3;
        wb_addr_lo = off;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] r, input logic [31:0] d);
        lu_valid = v;
        lu_rd    = r;
        lu_data  = d;
    endtask

    initial begin
        int stall_seen;
        int stale_wr;
        rst_n = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 3'b010, 2'd0);
        set_lu(1'b0, 5'd0, 32'h0);

        // ---- reset state ----
        #12;
        check("rst_wr_en", wr_en, 0);
        check("rst_lu_ready", lu_ready, 1);
        check("rst_pipe_stall", pipe_stall, 0);
        check("rst_misalign", misalign, 0);
        check("rst_rd", rd, 0);
        check("rst_rd_value", rd_value, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- back-to-back pipeline writes ----
        set_wb(1'b1, 5'd1, 32'h11, 1'b0, 3'b010, 2'd0);
        #1 check("b2b_accept", wb_accept, 1);
        tick();
        check("b2b1_wr_en", wr_en, 1);
        check("b2b1_rd", rd, 1);
        check("b2b1_val", rd_value, 32'h11);
        set_wb(1'b1, 5'd2, 32'h22, 1'b0, 3'b010, 2'd0);
        tick();
        check("b2b2_wr_en", wr_en, 1);
        check("b2b2_rd", rd, 2);
        check("b2b2_val", rd_value, 32'h22);
        set_wb(1'b1, 5'd3, 32'h33, 1'b0, 3'b010, 2'd0);
        tick();
        check("b2b3_wr_en", wr_en, 1);
        check("b2b3_rd", rd, 3);
        check("b2b3_val", rd_value, 32'h33);
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 3'b010, 2'd0);
        tick();
        check("idle_wr_en", wr_en, 0);
        check("idle_rd_hold", rd, 3);
        check("idle_val_hold", rd_value, 32'h33);

        // ---- x0 suppression, pipeline ----
        set_wb(1'b1, 5'd0, 32'h1234, 1'b0, 3'b010, 2'd0);
        #1 check("x0_accept", wb_accept, 1);
        tick();
        check("x0_wr_en", wr_en, 0);
        check("x0_val_hold", rd_value, 32'h33);

        // ---- load alignment, word 0x80FF7F01 ----
        set_wb(1'b1, 5'd7, 32'h80FF7F01, 1'b1, 3'b000, 2'd3);   // LB off 3
        tick();
        check("lb3_wr_en", wr_en, 1);
        check("lb3_val", rd_value, 32'hFFFFFF80);
        set_wb(1'b1, 5'd7, 32'h80FF7F01, 1'b1, 3'b100, 2'd2);   // LBU off 2
        tick();
        check("lbu2_val", rd_value, 32'h000000FF);
        set_wb(1'b1, 5'd7, 32'h80FF7F01, 1'b1, 3'b101, 2'd0);   // LHU off 0
        tick();
        check("lhu0_val", rd_value, 32'h00007F01);
        set_wb(1'b1, 5'd7, 32'h80FF7F01, 1'b1, 3'b010, 2'd0);   // LW off 0
        tick();
        check("lw0_val", rd_value, 32'h80FF7F01);
        set_wb(1'b1, 5'd7, 32'h80FF7F01, 1'b1, 3'b001, 2'd2);   // LH off 2
        tick();
        check("lh2_val", rd_value, 32'hFFFF80FF);
        check("lh2_misalign", misalign, 0);
        set_wb(1'b1, 5'd7, 32'h80FF7F01, 1'b1, 3'b001, 2'd1);   // LH off 1
        #1 check("lh1_accept", wb_accept, 1);
        tick();
        check("lh1_wr_en", wr_en, 0);
        check("lh1_misalign", misalign, 1);
        set_wb(1'b1, 5'd7, 32'h80FF7F01, 1'b1, 3'b010, 2'd2);   // LW off 2
        tick();
        check("lw2_wr_en", wr_en, 0);
        check("lw2_misalign", misalign, 1);
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 3'b010, 2'd0);
        tick();
        check("mis_pulse_end", misalign, 0);

        // ---- x0 suppression, long-latency ----
        set_lu(1'b1, 5'd0, 32'hBAD0);
        tick();
        set_lu(1'b0, 5'd0, 32'h0);
        check("lu_x0_count", dut.w_count, 0);
        check("lu_x0_ready", lu_ready, 1);
        tick();
        check("lu_x0_wr_en", wr_en, 0);

        // ---- starvation: pipeline busy, one lu result ----
        set_wb(1'b1, 5'd9, 32'h99, 1'b0, 3'b010, 2'd0);
        set_lu(1'b1, 5'd5, 32'hDEAD);
        tick();
        set_lu(1'b0, 5'd0, 32'h0);
        check("stv_pipe_wr", rd, 9);
        check("stv_count", dut.w_count, 1);
        stall_seen = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (pipe_stall !== 1'b0) stall_seen++;
        end
        check("stv_no_early_stall", stall_seen, 0);
        tick();
        check("stv_stall", pipe_stall, 1);
        check("stv_accept_blocked", wb_accept, 0);
        tick();
        check("stv_wr_en", wr_en, 1);
        check("stv_rd", rd, 5);
        check("stv_val", rd_value, 32'hDEAD);
        check("stv_stall_end", pipe_stall, 0);
        check("stv_accept_again", wb_accept, 1);

        // ---- full FIFO ----
        for (int i = 0; i < 4; i++) begin
            set_lu(1'b1, 5'(11 + i), 32'hA1 + 32'(i));
            tick();
        end
        check("full_ready", lu_ready, 0);
        check("full_count", dut.w_count, 4);
`ifdef WB_PENDING_MASK_EN
        check("full_mask", pending_mask, 32'h0000_7800);
`endif
        set_lu(1'b1, 5'd15, 32'hA5);
        tick();
        check("full_5th_refused", dut.w_count, 4);
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 3'b010, 2'd0);
        tick();
        check("drain1_rd", rd, 11);
        check("drain1_val", rd_value, 32'hA1);
        check("drain1_ready", lu_ready, 1);
        tick();
        set_lu(1'b0, 5'd0, 32'h0);
        check("drain2_rd", rd, 12);
        check("drain2_count", dut.w_count, 3);
        tick();
        check("drain3_rd", rd, 13);
        tick();
        check("drain4_rd", rd, 14);
        check("drain4_val", rd_value, 32'hA4);
        tick();
        check("drain5_rd", rd, 15);
        check("drain5_val", rd_value, 32'hA5);
        check("drain5_count", dut.w_count, 0);
        tick();
        check("drain_idle", wr_en, 0);
`ifdef WB_PENDING_MASK_EN
        check("drain_mask", pending_mask, 32'h0);
`endif

        // ---- reset mid-stream with 3 entries ----
        set_wb(1'b1, 5'd9, 32'h99, 1'b0, 3'b010, 2'd0);
        for (int i = 0; i < 3; i++) begin
            set_lu(1'b1, 5'(20 + i), 32'hC0 + 32'(i));
            tick();
        end
        set_lu(1'b0, 5'd0, 32'h0);
        check("mid_count", dut.w_count, 3);
        check("mid_wr_en", wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_ready", lu_ready, 1);
        check("mid_rst_count", dut.w_count, 0);
        set_wb(1'b0, 5'd0, 32'h0, 1'b0, 3'b010, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale_wr = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (wr_en !== 1'b0) stale_wr++;
        end
        check("mid_no_stale_write", stale_wr, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
